// File: rtl/fa_3bit_adder.sv
// Registered ripple-carry adder: {c3, s} = x + y + c0, captured one clock after in_valid.
// ovf flags two's-complement overflow of the WIDTH-bit sum.
module fa_3bit_adder #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    output logic [WIDTH-1:0] s,
    output logic             c3,
    output logic             ovf,
    output logic             out_valid
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;

    // Chain of single-bit full-adder cells, carry rippling from bit 0 upward.
    always_comb begin
        carry_c    = '0;
        sum_c      = '0;
        carry_c[0] = c0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_c[i]     = x[i] ^ y[i] ^ carry_c[i];
            carry_c[i+1] = (x[i] & y[i]) | (carry_c[i] & (x[i] ^ y[i]));
        end
        ovf_c = carry_c[WIDTH] ^ carry_c[MSB];
    end

    // Result register; operands are only looked at when in_valid is high,
    // so undefined inputs in idle cycles never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            c3        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s   <= sum_c;
                c3  <= carry_c[WIDTH];
                ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_fa_3bit_adder.sv
// Directed and sweep checks of fa_3bit_adder at WIDTH=3 and WIDTH=8.
module tb_fa_3bit_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, c0;
    logic [2:0] x, y, s;
    logic       c3, ovf, out_valid;

    logic       in_valid8, c08;
    logic [7:0] x8, y8, s8;
    logic       c38, ovf8, out_valid8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fa_3bit_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .c0(c0),
        .s(s), .c3(c3), .ovf(ovf), .out_valid(out_valid)
    );

    fa_3bit_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .x(x8), .y(y8), .c0(c08),
        .s(s8), .c3(c38), .ovf(ovf8), .out_valid(out_valid8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one valid vector to the 3-bit instance and check its result after the edge.
    task automatic step3(input string tag, input logic [2:0] vx, input logic [2:0] vy,
                         input logic vc, input logic [2:0] es, input logic ec3, input logic eovf);
        @(negedge clk);
        in_valid = 1'b1; x = vx; y = vy; c0 = vc;
        @(posedge clk);
        #1;
        check({tag, ".s"},         64'(s),         64'(es));
        check({tag, ".c3"},        64'(c3),        64'(ec3));
        check({tag, ".ovf"},       64'(ovf),       64'(eovf));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(1'b1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sum4;
        logic [8:0] sum9;
        logic [2:0] vx, vy;
        logic [7:0] wx, wy;
        logic       vc, wc;

        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; c0 = 1'b0;
        in_valid8 = 1'b0; x8 = '0; y8 = '0; c08 = 1'b0;

        // Reset held with clock running and random stimulus.
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'($urandom); x = 3'($urandom); y = 3'($urandom); c0 = 1'($urandom);
        end
        @(posedge clk);
        #1;
        check("rst.s",         64'(s),         64'(0));
        check("rst.c3",        64'(c3),        64'(0));
        check("rst.ovf",       64'(ovf),       64'(0));
        check("rst.out_valid", 64'(out_valid), 64'(0));

        // Release with in_valid low: outputs must stay clear.
        @(negedge clk);
        in_valid = 1'b0; x = 3'b111; y = 3'b111; c0 = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst.s",         64'(s),         64'(0));
        check("post_rst.c3",        64'(c3),        64'(0));
        check("post_rst.out_valid", 64'(out_valid), 64'(0));

        // Back-to-back directed vectors.
        step3("d000_001", 3'b000, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0);
        step3("d001_001", 3'b001, 3'b001, 1'b0, 3'b010, 1'b0, 1'b0);
        step3("d011_010", 3'b011, 3'b010, 1'b0, 3'b101, 1'b0, 1'b1);
        step3("d011_011", 3'b011, 3'b011, 1'b0, 3'b110, 1'b0, 1'b1);
        step3("d111_111", 3'b111, 3'b111, 1'b0, 3'b110, 1'b1, 1'b0);

        // Carry-in.
        step3("cin111_000", 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0);
        step3("cin000_000", 3'b000, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0);
        step3("wrap_cin",   3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 1'b0);

        // Hold on in_valid low.
        step3("hold_load", 3'b010, 3'b001, 1'b0, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; x = 3'b111; y = 3'b111; c0 = 1'b1;
        @(posedge clk);
        #1;
        check("hold.s",         64'(s),         64'(3'b011));
        check("hold.c3",        64'(c3),        64'(0));
        check("hold.ovf",       64'(ovf),       64'(0));
        check("hold.out_valid", 64'(out_valid), 64'(0));

        // Async reset between edges, after a valid 111+111.
        step3("pre_arst", 3'b111, 3'b111, 1'b0, 3'b110, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.s",         64'(s),         64'(0));
        check("arst.c3",        64'(c3),        64'(0));
        check("arst.out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_rel.out_valid", 64'(out_valid), 64'(0));
        step3("first_after_rst", 3'b001, 3'b010, 1'b1, 3'b100, 1'b0, 1'b1);

        // Exhaustive WIDTH=3 sweep.
        for (int i = 0; i < 128; i++) begin
            vx = 3'(i);
            vy = 3'(i >> 3);
            vc = 1'(i >> 6);
            sum4 = 4'(vx) + 4'(vy) + 4'(vc);
            step3("exh3", vx, vy, vc, sum4[2:0], sum4[3],
                  (vx[2] == vy[2]) && (sum4[2] != vx[2]));
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Random sweep at WIDTH=8, plus its all-ones corner.
        for (int i = 0; i < 201; i++) begin
            if (i == 0) begin
                wx = 8'hFF; wy = 8'hFF; wc = 1'b0;
            end else begin
                wx = 8'($urandom); wy = 8'($urandom); wc = 1'($urandom);
            end
            @(negedge clk);
            in_valid8 = 1'b1; x8 = wx; y8 = wy; c08 = wc;
            @(posedge clk);
            #1;
            sum9 = 9'(wx) + 9'(wy) + 9'(wc);
            check("rnd8.sum", 64'({c38, s8}), 64'(sum9));
            check("rnd8.ovf", 64'(ovf8),
                  64'((wx[7] == wy[7]) && (sum9[7] != wx[7])));
            check("rnd8.out_valid", 64'(out_valid8), 64'(1'b1));
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        check("rnd8.idle_valid", 64'(out_valid8), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fa_3bit_adder.md
Name:
fa_3bit_adder

Overview:
- Registered ripple-carry adder: sums two WIDTH-bit operands plus carry-in.
- Default width is 3 bits.
- Datapath is a chain of single-bit full-adder cells: sum = a^b^cin, cout = ab | cin(a^b).
- Result and carry-out are captured in an output register one clock after valid inputs are presented.
- Used as a small arithmetic leaf in datapath logic.

Parameters:
- WIDTH, 3, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x, y, c0 valid this cycle; sample them.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- c0  input  1  carry-in into bit 0.
- s  output  WIDTH  registered sum bits.
- c3  output  1  registered carry-out of MSB (name kept for WIDTH=3 compatibility).
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  s/c3/ovf hold a fresh result.

Behaviour:
- Reset: rst_n low forces s=0, c3=0, ovf=0, out_valid=0 immediately, independent of clk. Values are held while rst_n stays low.
- Reset release: takes effect at the next rising clk edge with rst_n high.
- Combinational core:
  - carry[0]=c0.
  - For i in 0..WIDTH-1: sum[i]=x[i]^y[i]^carry[i]; carry[i+1]=(x[i]&y[i])|(carry[i]&(x[i]^y[i])).
  - Result is {carry[WIDTH], sum} = x + y + c0 exactly, modulo 2^(WIDTH+1).
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge N, s/c3/ovf reflect those inputs after edge N, and out_valid=1 for that cycle.
- in_valid=0 at an edge:
  - s, c3, ovf hold their previous values.
  - out_valid goes 0.
- Throughput: one addition per cycle. Back-to-back valid inputs produce back-to-back valid outputs; there is no back-pressure.
- X/undefined inputs with in_valid=0 must not disturb the outputs.
- Wrap-around: all-ones + all-ones + c0 gives s = all-ones minus 1 + c0, with c3=1. The sum always wraps modulo 2^WIDTH and the carry goes to c3.
- ovf treats x, y, s as two's complement. Example: WIDTH=3, 011+010 gives s=101, ovf=1, c3=0.
- Reset asserted mid-stream discards any pending result. The first valid output after release comes from the first post-reset in_valid.
- No internal state other than the output registers.

Test Plan:
- Reset: rst_n=0 with clk running and random inputs -> s=000, c3=0, ovf=0, out_valid=0. Deassert -> outputs stay 0 until the first in_valid.
- Directed sequence, c0=0, in_valid=1, one vector per cycle; each result checked one cycle later with out_valid=1:
  - 000+001 -> s=001, c3=0.
  - 001+001 -> s=010, c3=0.
  - 011+010 -> s=101, c3=0, ovf=1.
  - 011+011 -> s=110, c3=0, ovf=1.
  - 111+111 -> s=110, c3=1, ovf=0.
- Carry-in: x=111, y=000, c0=1 -> s=000, c3=1; x=000, y=000, c0=1 -> s=001, c3=0.
- Hold: valid 010+001 (s=011), then in_valid=0 with x=111, y=111 -> s stays 011, out_valid drops to 0.
- Async reset mid-stream: assert rst_n low between clock edges after a valid 111+111 -> s, c3 clear immediately, without waiting for clk.
- Exhaustive: all 128 combinations of x, y, c0 for WIDTH=3 -> {c3,s} == x+y+c0 one cycle later. Repeat a random sweep at WIDTH=8.
